counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_if.sv | 39 +++
 rtl/counter_next.sv | 42 ++++
 rtl/counter.sv | 53 +++++
 tb/tb_counter.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults and direction encodings for the counter.
// Optional feature macro: COUNTER_LOAD_EN (parallel load port on counter).
package counter_pkg;

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_MAX_COUNT = 7;

    // Encodings of the 'up' direction input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_if.sv
// counter_if: groups the counter control/status signals for a driver.
// Ports: en, up -> counter; q, tc <- counter; load, load_val with COUNTER_LOAD_EN.
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             en;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             tc;
`ifdef COUNTER_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] load_val;
`endif

    modport master (
        output en,
        output up,
`ifdef COUNTER_LOAD_EN
        output load,
        output load_val,
`endif
        input  q,
        input  tc
    );

    modport slave (
        input  en,
        input  up,
`ifdef COUNTER_LOAD_EN
        input  load,
        input  load_val,
`endif
        output q,
        output tc
    );

endinterface

// File: rtl/counter_next.sv
// counter_next: combinational next-count with modulo wrap and load.
// Ports: i_q current, i_en, i_up, [i_load, i_load_val], o_next. Macro: COUNTER_LOAD_EN.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_en,
    input  logic             i_up,
`ifdef COUNTER_LOAD_EN
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
`endif
    output logic [WIDTH-1:0] o_next
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    always_comb begin
        o_next = i_q;
`ifdef COUNTER_LOAD_EN
        if (i_load) begin
            // Out-of-range load values saturate at the terminal value
            o_next = (i_load_val > MAX_V) ? MAX_V : i_load_val;
        end else
`endif
        if (i_q > MAX_V) begin
            // Recover from an illegal count with a non-power-of-two modulus
            o_next = '0;
        end else if (i_en) begin
            if (i_up == DIR_UP) begin
                o_next = (i_q == MAX_V) ? '0 : i_q + ONE_V;
            end else begin
                o_next = (i_q == '0) ? MAX_V : i_q - ONE_V;
            end
        end
    end

endmodule

// File: rtl/counter.sv
// counter: up/down modulo counter, count register and terminal-count flag.
// Ports: clk, reset (async low), q, en, up, tc, [load, load_val]. Macro: COUNTER_LOAD_EN.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up,
    output logic             tc
`ifdef COUNTER_LOAD_EN
    ,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    counter_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next (
        .i_q        (r_q),
        .i_en       (en),
        .i_up       (up),
`ifdef COUNTER_LOAD_EN
        .i_load     (load),
        .i_load_val (load_val),
`endif
        .o_next     (w_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q  = r_q;
    assign tc = en & (((up == DIR_UP) && (r_q == MAX_V)) ||
                      ((up == DIR_DOWN) && (r_q == '0)));

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed self-checking bench for counter (MAX 7 and MAX 5).
// Load checks are included when COUNTER_LOAD_EN is defined.
module tb_counter;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_pass;

    counter_if #(.WIDTH(3)) bus  ();
    counter_if #(.WIDTH(3)) bus5 ();

    counter #(.WIDTH(3), .MAX_COUNT(7)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .q        (bus.q),
        .en       (bus.en),
        .up       (bus.up),
        .tc       (bus.tc)
`ifdef COUNTER_LOAD_EN
        ,
        .load     (bus.load),
        .load_val (bus.load_val)
`endif
    );

    counter #(.WIDTH(3), .MAX_COUNT(5)) dut5 (
        .clk      (clk),
        .reset    (rst_n),
        .q        (bus5.q),
        .en       (bus5.en),
        .up       (bus5.up),
        .tc       (bus5.tc)
`ifdef COUNTER_LOAD_EN
        ,
        .load     (bus5.load),
        .load_val (bus5.load_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.up  = 1'b1;
        bus5.en = 1'b0;
        bus5.up = 1'b1;
`ifdef COUNTER_LOAD_EN
        bus.load      = 1'b0;
        bus.load_val  = 3'd0;
        bus5.load     = 1'b0;
        bus5.load_val = 3'd0;
`endif
        #1;
        check("rst_q", int'(bus.q), 0);
        check("rst_tc", int'(bus.tc), 0);

        // release at 10 ns, between edges
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_q", int'(bus.q), 0);

        // count up 1..7 then wrap to 0
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("up_q", int'(bus.q), i % 8);
            check("up_tc", int'(bus.tc), (i == 7) ? 1 : 0);
        end

        // count down from 0
        bus.up = 1'b0;
        #1;
        check("dn_tc0", int'(bus.tc), 1);
        @(negedge clk);
        check("dn_q7", int'(bus.q), 7);
        check("dn_tc7", int'(bus.tc), 0);
        @(negedge clk);
        check("dn_q6", int'(bus.q), 6);
        @(negedge clk);
        check("dn_q5", int'(bus.q), 5);

        // async reset between edges, held across one edge with en=1
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", int'(bus.q), 0);
        check("arst_tc", int'(bus.tc), 1);
        @(negedge clk);
        check("arst_hold", int'(bus.q), 0);
        rst_n  = 1'b1;
        bus.up = 1'b1;
        @(negedge clk);
        check("res_q1", int'(bus.q), 1);
        @(negedge clk);
        check("res_q2", int'(bus.q), 2);
        @(negedge clk);
        check("res_q3", int'(bus.q), 3);

        // hold with en=0
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_q", int'(bus.q), 3);
            check("hold_tc", int'(bus.tc), 0);
        end

        // modulus 5 instance
        check("m5_q0", int'(bus5.q), 0);
        bus5.en = 1'b1;
        bus5.up = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("m5_q", int'(bus5.q), i % 6);
            check("m5_tc", int'(bus5.tc), (i == 5) ? 1 : 0);
        end
        bus5.up = 1'b0;
        #1;
        check("m5_dn_tc", int'(bus5.tc), 1);
        @(negedge clk);
        check("m5_dn_q", int'(bus5.q), 5);
        bus5.en = 1'b0;

`ifdef COUNTER_LOAD_EN
        bus.en        = 1'b1;
        bus.up        = 1'b1;
        bus.load      = 1'b1;
        bus.load_val  = 3'd6;
        bus5.en       = 1'b1;
        bus5.load     = 1'b1;
        bus5.load_val = 3'd7;
        @(negedge clk);
        check("ld_q6", int'(bus.q), 6);
        check("ld_sat", int'(bus5.q), 5);
        bus.load  = 1'b0;
        bus5.load = 1'b0;
        @(negedge clk);
        check("ld_next", int'(bus.q), 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
